grey_step_decoder: RTL and testbench

GREY_STEP_DECODER -- requirements
Module: grey_step_decoder

---
 rtl/grey_pkg.sv | 12 +
 rtl/grey2bin.sv | 21 ++
 rtl/grey_step_decoder.sv | 137 +++++++++++++
 tb/tb_grey_step_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/grey_pkg.sv
// rtl/grey_pkg.sv - shared types and constants for the Gray step decoder
package grey_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int ERR_CNT_W = 8;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

endpackage

// File: rtl/grey2bin.sv
// rtl/grey2bin.sv - combinational Gray-to-binary converter
module grey2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] grey,
    output logic [WIDTH-1:0] bin
);

    logic acc;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        acc = 1'b0;
        bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ grey[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/grey_step_decoder.sv
// rtl/grey_step_decoder.sv - locks onto a Gray counter and decodes steps; GREY_ERR_CNT_EN enables the error counter
module grey_step_decoder
    import grey_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LOCK_CNT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [WIDTH-1:0]     grey_i,
    output logic [WIDTH-1:0]     bin_o,
    output logic                 valid_o,
    output logic                 dir_o,
    output logic                 wrap_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 locked_o
);

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT - 1);
    localparam logic [WIDTH-1:0] BIN_MAX  = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [3:0]       cnt_q, cnt_d, cnt_nxt;
    logic             primed_q, primed_d;
    logic             dir_q, dir_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] cur_bin;
    logic [WIDTH-1:0] diff;
    logic             same, single;

    grey2bin #(.WIDTH(WIDTH)) u_grey2bin (
        .grey (grey_i),
        .bin  (cur_bin)
    );

    assign diff   = grey_i ^ prev_q;
    assign same   = (diff == '0);
    assign single = !same && ((diff & (diff - 1'b1)) == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= UNLOCKED;
            prev_q   <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            dir_q    <= 1'b0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            dir_q    <= dir_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        dir_d    = dir_q;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        // The reset value of prev_q is not a real sample, so it never counts as a match.
        cnt_nxt  = (primed_q && same) ? cnt_q + 4'd1 : 4'd0;

        if (en_i) begin
            prev_d   = grey_i;
            primed_d = 1'b1;
            case (state_q)
                UNLOCKED: begin
                    if (cnt_nxt >= LOCK_TGT) begin
                        state_d = LOCKED;
                        bin_d   = cur_bin;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_nxt;
                    end
                end
                LOCKED: begin
                    if (single) begin
                        bin_d   = cur_bin;
                        valid_d = 1'b1;
                        dir_d   = (cur_bin == bin_q + 1'b1);
                        wrap_d  = ((bin_q == BIN_MAX) && (cur_bin == '0)) ||
                                  ((bin_q == '0) && (cur_bin == BIN_MAX));
                    end else if (!same) begin
                        err_d   = 1'b1;
                        state_d = UNLOCKED;
                        cnt_d   = '0;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

`ifdef GREY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    assign bin_o    = bin_q;
    assign valid_o  = valid_q;
    assign dir_o    = dir_q;
    assign wrap_o   = wrap_q;
    assign err_o    = err_q;
    assign locked_o = (state_q == LOCKED);

endmodule

// File: tb/tb_grey_step_decoder.sv
// tb/tb_grey_step_decoder.sv - directed and randomized checks of grey_step_decoder against a behavioural model
module tb_grey_step_decoder;

    localparam int W    = 4;
    localparam int N    = 1 << W;
    localparam int LOCK = 2;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         en_i;
    logic [W-1:0] grey_i;
    logic [W-1:0] bin_o;
    logic         valid_o, dir_o, wrap_o, err_o, locked_o;
    logic [7:0]   err_cnt_o;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit           m_locked, m_primed, m_valid, m_wrap, m_err, m_dir;
    logic [W-1:0] m_prev, m_bin;
    int           m_run, m_errs;

    grey_step_decoder #(.WIDTH(W), .LOCK_CNT(LOCK)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (en_i),
        .grey_i    (grey_i),
        .bin_o     (bin_o),
        .valid_o   (valid_o),
        .dir_o     (dir_o),
        .wrap_o    (wrap_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o),
        .locked_o  (locked_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inverse found by search over the encoding, not by a bit recurrence.
    function automatic logic [W-1:0] g2b_ref(input logic [W-1:0] g);
        for (int b = 0; b < N; b++)
            if (b2g(W'(b)) == g) return W'(b);
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_err_cnt();
`ifdef GREY_ERR_CNT_EN
        return (m_errs > 255) ? 8'd255 : 8'(m_errs);
`else
        return 8'd0;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".bin"},     8'(bin_o),    8'(m_bin));
        chk({tag, ".valid"},   8'(valid_o),  8'(m_valid));
        chk({tag, ".dir"},     8'(dir_o),    8'(m_dir));
        chk({tag, ".wrap"},    8'(wrap_o),   8'(m_wrap));
        chk({tag, ".err"},     8'(err_o),    8'(m_err));
        chk({tag, ".errcnt"},  err_cnt_o,    exp_err_cnt());
        chk({tag, ".locked"},  8'(locked_o), 8'(m_locked));
    endtask

    task automatic model_reset();
        m_locked = 0; m_primed = 0; m_valid = 0; m_wrap = 0; m_err = 0; m_dir = 0;
        m_prev = '0; m_bin = '0; m_run = 0; m_errs = 0;
    endtask

    task automatic model_step(input bit en, input logic [W-1:0] g);
        int d;
        logic [W-1:0] nb;
        m_valid = 0; m_wrap = 0; m_err = 0;
        if (!en) return;
        nb = g2b_ref(g);
        d  = $countones(g ^ m_prev);
        if (!m_locked) begin
            m_run = (m_primed && d == 0) ? m_run + 1 : 0;
            if (m_run >= LOCK - 1) begin
                m_locked = 1;
                m_bin    = nb;
                m_run    = 0;
            end
        end else if (d == 1) begin
            m_valid = 1;
            m_dir   = (int'(nb) == (int'(m_bin) + 1) % N);
            m_wrap  = (int'(m_bin) == N - 1 && nb == 0) || (m_bin == 0 && int'(nb) == N - 1);
            m_bin   = nb;
        end else if (d >= 2) begin
            m_err    = 1;
            m_errs   = m_errs + 1;
            m_locked = 0;
            m_run    = 0;
        end
        m_prev   = g;
        m_primed = 1;
    endtask

    task automatic apply(input string tag, input bit en, input logic [W-1:0] g);
        en_i   = en;
        grey_i = g;
        model_step(en, g);
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    task automatic step_bin(input string tag, input int b);
        apply(tag, 1'b1, b2g(W'(b % N)));
    endtask

    logic [W-1:0] g;
    int           r;

    initial begin
        rst_n_i = 1'b0;
        en_i    = 1'b0;
        grey_i  = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // lock on two identical samples
        apply("lock0", 1'b1, 4'b0000);
        apply("lock1", 1'b1, 4'b0000);
        chk("lock1.locked_const", 8'(locked_o), 8'd1);

        // count up
        apply("up1", 1'b1, 4'b0001);
        apply("up2", 1'b1, 4'b0011);
        apply("up3", 1'b1, 4'b0010);
        chk("up3.bin_const", 8'(bin_o), 8'd3);
        chk("up3.dir_const", 8'(dir_o), 8'd1);

        // walk to 15, then wrap up and down
        for (int b = 4; b < N; b++) step_bin("walk", b);
        apply("wrap_up", 1'b1, 4'b0000);
        chk("wrap_up.bin_const",  8'(bin_o),  8'd0);
        chk("wrap_up.wrap_const", 8'(wrap_o), 8'd1);
        apply("wrap_dn", 1'b1, 4'b1000);
        chk("wrap_dn.bin_const", 8'(bin_o), 8'd15);
        chk("wrap_dn.dir_const", 8'(dir_o), 8'd0);

        // illegal step and relock
        apply("to0", 1'b1, 4'b0000);
        apply("to1", 1'b1, 4'b0001);
        apply("to2", 1'b1, 4'b0011);
        apply("illegal", 1'b1, 4'b0101);
        chk("illegal.err_const",    8'(err_o),    8'd1);
        chk("illegal.bin_const",    8'(bin_o),    8'd2);
        chk("illegal.locked_const", 8'(locked_o), 8'd0);
        apply("relock0", 1'b1, 4'b0101);
        apply("relock1", 1'b1, 4'b0101);
        chk("relock.bin_const",    8'(bin_o),    8'd6);
        chk("relock.locked_const", 8'(locked_o), 8'd1);

        // disabled cycles with random input
        for (int i = 0; i < 5; i++) apply("en_off", 1'b0, W'($urandom));

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      apply("rnd_off",  1'b0, W'($urandom));
            else if (r == 1) apply("rnd_jump", 1'b1, W'($urandom));
            else if (r < 4)  apply("rnd_hold", 1'b1, m_prev);
            else if (r < 7)  step_bin("rnd_up", int'(g2b_ref(m_prev)) + 1);
            else             step_bin("rnd_dn", int'(g2b_ref(m_prev)) + N - 1);
        end

        // drive well past 255 errors: each pair relocks then breaks lock
        for (int i = 0; i < 310; i++) begin
            g = (i % 2 == 0) ? 4'b0011 : 4'b0000;
            apply("errs_a", 1'b1, g);
            apply("errs_b", 1'b1, g);
        end

        // asynchronous reset between edges, mid-stream
        step_bin("pre_rst", int'(g2b_ref(m_prev)) + 1);
        #3;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        en_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        apply("post_rst0", 1'b1, 4'b0110);
        apply("post_rst1", 1'b1, 4'b0110);
        apply("post_rst2", 1'b1, 4'b0111);
        chk("post_rst.bin_const", 8'(bin_o), 8'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
